// File: rtl/hart_pkg.sv
// Shared definitions for the hart controller and the single-cycle RV64I core.
// Holds the execution-state enum, the interrupt bit indices that the core
// uses to build its interrupts vector, the trap cause codes, and the
// is_fatal() helper that tells terminal traps apart from ECALL/EBREAK.
package hart_pkg;

    // Execution state of the hart; encoding is visible on state_o.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } hart_state_e;

    // Bit positions inside the core's 6-bit interrupts vector.
    localparam int NUM_IRQ              = 6;
    localparam int IRQ_FETCH_ERROR      = 0;
    localparam int IRQ_DECODE_ERROR     = 1;
    localparam int IRQ_MEM_ACCESS_ERROR = 2;
    localparam int IRQ_UNKNOWN_BRTY     = 3;
    localparam int IRQ_ECALL            = 4;
    localparam int IRQ_EBREAK           = 5;

    // Trap cause codes: 0..5 equal the interrupt bit index, 6 is a
    // misaligned next PC detected by the controller itself.
    typedef enum logic [2:0] {
        CAUSE_FETCH_ERROR      = 3'd0,
        CAUSE_DECODE_ERROR     = 3'd1,
        CAUSE_MEM_ACCESS_ERROR = 3'd2,
        CAUSE_UNKNOWN_BRTY     = 3'd3,
        CAUSE_ECALL            = 3'd4,
        CAUSE_EBREAK           = 3'd5,
        CAUSE_INSTR_MISALIGNED = 3'd6
    } cause_e;

    // Fatal causes halt the hart permanently (only reset recovers).
    function automatic logic is_fatal(input cause_e cause);
        return !((cause == CAUSE_ECALL) || (cause == CAUSE_EBREAK));
    endfunction

endpackage

// File: rtl/hart_controller_if.sv
// Connection between the hart controller and the combinational core.
// Signals:
//   pc_o         controller -> core  current PC (core's pc_i)
//   new_pc_i     core -> controller  next PC computed by the core
//   interrupts_i core -> controller  per-instruction event flags
// Modports: master = controller side, slave = core side.
interface hart_controller_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] pc_o;
    logic [DATA_WIDTH-1:0] new_pc_i;
    logic [5:0]            interrupts_i;

    modport master (
        output pc_o,
        input  new_pc_i,
        input  interrupts_i
    );

    modport slave (
        input  pc_o,
        output new_pc_i,
        output interrupts_i
    );
endinterface

// File: rtl/trap_priority_encoder.sv
// Combinational trap cause selection.
// Ports:
//   interrupts_i  in  6  core event flags (bit index == cause code)
//   new_pc_lsb_i  in  2  low bits of the core's next PC
//   event_valid   out 1  some trap condition is present this cycle
//   cause         out 3  winning cause; lowest interrupt bit wins,
//                        misalignment only counts when no interrupt is set
module trap_priority_encoder
    import hart_pkg::*;
(
    input  logic [5:0] interrupts_i,
    input  logic [1:0] new_pc_lsb_i,
    output logic       event_valid,
    output cause_e     cause
);

    always_comb begin
        event_valid = 1'b0;
        cause       = CAUSE_FETCH_ERROR;
        if (|interrupts_i) begin
            event_valid = 1'b1;
            // Walk from the highest bit down so the lowest set bit is the
            // last assignment and therefore wins.
            for (int i = NUM_IRQ - 1; i >= 0; i--) begin
                if (interrupts_i[i]) begin
                    cause = cause_e'(i[2:0]);
                end
            end
        end else if (|new_pc_lsb_i) begin
            event_valid = 1'b1;
            cause       = CAUSE_INSTR_MISALIGNED;
        end
    end

endmodule

// File: rtl/hart_controller.sv
// Architectural PC and execution-state owner for the single-cycle RV64I core.
// Each cycle in RUN/STEP it either commits the core's next PC, redirects to
// the trap vector on ECALL, or halts on EBREAK / fatal events.
// Ports:
//   clk_i         in   clock
//   rst_ni        in   asynchronous active-low reset
//   run_i         in   IDLE -> RUN (priority over step_i)
//   step_i        in   IDLE -> STEP (one instruction, then IDLE)
//   resume_i      in   HALT -> RUN at epc+4, only after EBREAK
//   core          if   master modport: pc_o out, new_pc_i/interrupts_i in
//   state_o       out  IDLE=0, RUN=1, STEP=2, HALT=3
//   halted_o      out  decoded from the state register
//   trap_valid_o  out  a trap has been recorded since reset
//   trap_cause_o  out  last recorded cause code
//   epc_o         out  PC of the trapping instruction
//   retired_o     out  committed instruction count (wraps)
module hart_controller
    import hart_pkg::*;
#(
    parameter int                    DATA_WIDTH = 64,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] TRAP_VEC   = DATA_WIDTH'(64'h100)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  run_i,
    input  logic                  step_i,
    input  logic                  resume_i,
    hart_controller_if.master     core,
    output logic [1:0]            state_o,
    output logic                  halted_o,
    output logic                  trap_valid_o,
    output logic [2:0]            trap_cause_o,
    output logic [DATA_WIDTH-1:0] epc_o,
    output logic [DATA_WIDTH-1:0] retired_o
);

    localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] INSN_LEN = DATA_WIDTH'(4);

    hart_state_e           state_reg;
    logic [DATA_WIDTH-1:0] pc_reg;
    logic [DATA_WIDTH-1:0] epc_reg;
    logic [DATA_WIDTH-1:0] retired_reg;
    cause_e                cause_reg;
    logic                  trap_valid_reg;

    logic   ev_valid;
    cause_e ev_cause;

    trap_priority_encoder u_trap_priority_encoder (
        .interrupts_i (core.interrupts_i),
        .new_pc_lsb_i (core.new_pc_i[1:0]),
        .event_valid  (ev_valid),
        .cause        (ev_cause)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= ST_IDLE;
            pc_reg         <= RESET_PC;
            epc_reg        <= '0;
            retired_reg    <= '0;
            cause_reg      <= CAUSE_FETCH_ERROR;
            trap_valid_reg <= 1'b0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (run_i) begin
                        state_reg <= ST_RUN;
                    end else if (step_i) begin
                        state_reg <= ST_STEP;
                    end
                end

                ST_RUN, ST_STEP: begin
                    if (!ev_valid) begin
                        pc_reg      <= core.new_pc_i;
                        retired_reg <= retired_reg + ONE;
                        if (state_reg == ST_STEP) begin
                            state_reg <= ST_IDLE;
                        end
                    end else begin
                        epc_reg        <= pc_reg;
                        cause_reg      <= ev_cause;
                        trap_valid_reg <= 1'b1;
                        if (is_fatal(ev_cause)) begin
                            // Faulting instruction does not retire; PC held.
                            state_reg <= ST_HALT;
                        end else begin
                            // ECALL and EBREAK both retire the instruction.
                            retired_reg <= retired_reg + ONE;
                            if (ev_cause == CAUSE_EBREAK) begin
                                state_reg <= ST_HALT;
                            end else begin
                                pc_reg <= TRAP_VEC;
                                if (state_reg == ST_STEP) begin
                                    state_reg <= ST_IDLE;
                                end
                            end
                        end
                    end
                end

                ST_HALT: begin
                    // Only a breakpoint halt is resumable.
                    if (resume_i && (cause_reg == CAUSE_EBREAK)) begin
                        pc_reg    <= epc_reg + INSN_LEN;
                        state_reg <= ST_RUN;
                    end
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign core.pc_o     = pc_reg;
    assign state_o       = state_reg;
    assign halted_o      = (state_reg == ST_HALT);
    assign trap_valid_o  = trap_valid_reg;
    assign trap_cause_o  = cause_reg;
    assign epc_o         = epc_reg;
    assign retired_o     = retired_reg;

endmodule

// File: tb/tb_hart_controller.sv
// Self-checking bench for hart_controller: a behavioural model of the hart
// is compared against the DUT on every falling edge, and directed
// scenarios pin the model with hand-computed literal values.
module tb_hart_controller;

    localparam logic [63:0] RESET_PC = 64'h0;
    localparam logic [63:0] TRAP_VEC = 64'h100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        resume = 1'b0;
    logic        use_core = 1'b1;
    logic [63:0] npc_force = 64'h0;
    logic [5:0]  irq = 6'h0;

    logic [1:0]  state;
    logic        halted;
    logic        tv;
    logic [2:0]  cause;
    logic [63:0] epc;
    logic [63:0] retired;

    int n_checks = 0;
    int n_fail   = 0;

    hart_controller_if #(.DATA_WIDTH(64)) core_if ();

    // Core stand-in: either sequential fetch (pc+4) or a forced next PC.
    assign core_if.new_pc_i     = use_core ? core_if.pc_o + 64'd4 : npc_force;
    assign core_if.interrupts_i = irq;

    hart_controller #(
        .DATA_WIDTH (64),
        .RESET_PC   (RESET_PC),
        .TRAP_VEC   (TRAP_VEC)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .run_i        (run),
        .step_i       (step),
        .resume_i     (resume),
        .core         (core_if.master),
        .state_o      (state),
        .halted_o     (halted),
        .trap_valid_o (tv),
        .trap_cause_o (cause),
        .epc_o        (epc),
        .retired_o    (retired)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [63:0] pc;
        logic [1:0]  st;     // 0 idle, 1 run, 2 step, 3 halt
        logic        tv;
        logic [2:0]  cause;
        logic [63:0] epc;
        logic [63:0] ret;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r     = '0;
        r.pc  = RESET_PC;
        return r;
    endfunction

    function automatic model_t model_next(input model_t c, input logic r_run,
                                          input logic r_step, input logic r_resume,
                                          input logic [63:0] npc, input logic [5:0] ev);
        model_t n;
        int     code;
        n = c;
        if (c.st == 2'd0) begin
            if (r_run)       n.st = 2'd1;
            else if (r_step) n.st = 2'd2;
        end else if (c.st == 2'd3) begin
            if (r_resume && c.cause == 3'd5) begin
                n.pc = c.epc + 64'd4;
                n.st = 2'd1;
            end
        end else begin
            code = -1;
            for (int i = 0; i < 6; i++) begin
                if (code < 0 && ev[i]) code = i;
            end
            if (code < 0 && npc[1:0] != 2'b00) code = 6;
            if (code < 0) begin
                n.pc  = npc;
                n.ret = c.ret + 64'd1;
                if (c.st == 2'd2) n.st = 2'd0;
            end else begin
                n.epc   = c.pc;
                n.cause = 3'(code);
                n.tv    = 1'b1;
                if (code == 4) begin
                    n.pc  = TRAP_VEC;
                    n.ret = c.ret + 64'd1;
                    if (c.st == 2'd2) n.st = 2'd0;
                end else if (code == 5) begin
                    n.ret = c.ret + 64'd1;
                    n.st  = 2'd3;
                end else begin
                    n.st = 2'd3;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m <= model_reset();
        end else begin
            m <= model_next(m, run, step, resume,
                            use_core ? m.pc + 64'd4 : npc_force, irq);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cyc_pc",      core_if.pc_o, m.pc);
        chk("cyc_state",   64'(state),   64'(m.st));
        chk("cyc_halted",  64'(halted),  64'(m.st == 2'd3));
        chk("cyc_tvalid",  64'(tv),      64'(m.tv));
        chk("cyc_cause",   64'(cause),   64'(m.cause));
        chk("cyc_epc",     epc,          m.epc);
        chk("cyc_retired", retired,      m.ret);
    end

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_pc", core_if.pc_o, 64'h0);
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_retired", retired, 64'd0);
        chk("rst_tvalid", 64'(tv), 64'd0);
        rst_n = 1'b1;

        // Run five sequential instructions
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        repeat (5) @(negedge clk);
        chk("run_pc", core_if.pc_o, 64'h14);
        chk("run_retired", retired, 64'd5);
        chk("run_state", 64'(state), 64'd1);

        // ECALL at 0x20
        repeat (3) @(negedge clk);
        irq = 6'b010000;
        @(negedge clk);
        irq = 6'b0;
        chk("ecall_pc", core_if.pc_o, 64'h100);
        chk("ecall_epc", epc, 64'h20);
        chk("ecall_cause", 64'(cause), 64'd4);
        chk("ecall_retired", retired, 64'd9);
        chk("ecall_state", 64'(state), 64'd1);

        // MemAccess + EBREAK at 0x40: MemAccess wins, fatal halt
        use_core  = 1'b0;
        npc_force = 64'h40;
        @(negedge clk);
        irq = 6'b100100;
        @(negedge clk);
        irq = 6'b0;
        chk("fatal_state", 64'(state), 64'd3);
        chk("fatal_cause", 64'(cause), 64'd2);
        chk("fatal_pc", core_if.pc_o, 64'h40);
        chk("fatal_retired", retired, 64'd10);
        chk("fatal_halted", 64'(halted), 64'd1);
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        run = 1'b1;
        step = 1'b1;
        @(negedge clk);
        run = 1'b0;
        step = 1'b0;
        chk("fatal_stuck_state", 64'(state), 64'd3);
        chk("fatal_stuck_pc", core_if.pc_o, 64'h40);

        // EBREAK at 0x80, then resume
        do_reset();
        npc_force = 64'h80;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        irq = 6'b100000;
        @(negedge clk);
        irq = 6'b0;
        chk("ebrk_state", 64'(state), 64'd3);
        chk("ebrk_cause", 64'(cause), 64'd5);
        chk("ebrk_epc", epc, 64'h80);
        chk("ebrk_retired", retired, 64'd2);
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        chk("resume_pc", core_if.pc_o, 64'h84);
        chk("resume_state", 64'(state), 64'd1);

        // epc+4 wraps at the top of the address space
        npc_force = 64'hFFFF_FFFF_FFFF_FFFC;
        @(negedge clk);
        irq = 6'b100000;
        @(negedge clk);
        irq = 6'b0;
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        chk("wrap_pc", core_if.pc_o, 64'h0);

        // Single step, events ignored in IDLE, misaligned step
        do_reset();
        npc_force = 64'h8;
        irq = 6'b111111;
        @(negedge clk);
        irq = 6'b0;
        chk("idle_ignore_state", 64'(state), 64'd0);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        chk("step_pc", core_if.pc_o, 64'h8);
        chk("step_retired", retired, 64'd1);
        chk("step_state", 64'(state), 64'd0);
        step = 1'b1;
        npc_force = 64'h6;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        chk("mis_state", 64'(state), 64'd3);
        chk("mis_cause", 64'(cause), 64'd6);
        chk("mis_epc", epc, 64'h8);
        chk("mis_retired", retired, 64'd1);

        // run has priority over step
        do_reset();
        run = 1'b1;
        step = 1'b1;
        @(negedge clk);
        run = 1'b0;
        step = 1'b0;
        chk("prio_state", 64'(state), 64'd1);

        // ECALL during STEP returns to IDLE at the trap vector
        do_reset();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        irq = 6'b010000;
        @(negedge clk);
        irq = 6'b0;
        chk("step_ecall_state", 64'(state), 64'd0);
        chk("step_ecall_pc", core_if.pc_o, 64'h100);

        // Asynchronous reset in the middle of RUN
        do_reset();
        use_core = 1'b1;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_areset_pc", core_if.pc_o, 64'hC);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_pc", core_if.pc_o, RESET_PC);
        chk("areset_state", 64'(state), 64'd0);
        chk("areset_retired", retired, 64'd0);
        chk("areset_epc", epc, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hart_controller.md
Name: hart_controller

Overview:
Owns the architectural PC and execution state for the single-cycle RV64I core.
- Feeds pc_o into the core's pc_i.
- Consumes the core's new_pc_o and the 6-bit interrupts_o vector.
- Decides each cycle whether to commit, redirect to the trap vector, or halt.
- Provides run/step/resume control, trap cause/EPC capture and a retired-instruction counter for the bench and debug.

Parameters:
- DATA_WIDTH, 64, width of PC, EPC and counters.
- RESET_PC, 64'h0, PC value after reset.
- TRAP_VEC, 64'h100, PC loaded on ECALL.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- run_i  input  1  start continuous execution from IDLE.
- step_i  input  1  execute exactly one instruction from IDLE.
- resume_i  input  1  leave HALT after EBREAK.
- new_pc_i  input  DATA_WIDTH  next PC computed by the core.
- interrupts_i  input  6  core events: bit0 FetchError, bit1 DecodeError, bit2 MemAccessError, bit3 UnknownBrtyError, bit4 ECALL, bit5 EBREAK.
- pc_o  output  DATA_WIDTH  current PC, drives the core.
- state_o  output  2  IDLE=0, RUN=1, STEP=2, HALT=3.
- halted_o  output  1  state_o==HALT.
- trap_valid_o  output  1  at least one trap has been recorded since reset.
- trap_cause_o  output  3  last recorded cause code: 0–5 = interrupt bit index, 6 = InstrMisaligned.
- epc_o  output  DATA_WIDTH  PC of the instruction that trapped.
- retired_o  output  DATA_WIDTH  count of committed instructions.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - pc_o=RESET_PC, state IDLE, halted_o=0, trap_valid_o=0, trap_cause_o=0, epc_o=0, retired_o=0.
  - Reset mid-RUN aborts immediately; no partial commit.
- Event sampling: the core is combinational from pc_o. interrupts_i and new_pc_i are sampled on every rising edge while state is RUN or STEP. They are ignored in IDLE and HALT.
- Cause selection (fixed priority, lowest bit wins): 0 > 1 > 2 > 3 > 4 > 5.
  - Misaligned (6) applies only when interrupts_i==0 and new_pc_i[1:0]!=0.
  - Only the winning cause is recorded.
- Actions per cycle in RUN/STEP:
  - No event: pc_o<=new_pc_i, retired_o+=1.
  - Fatal (causes 0,1,2,3,6): epc_o<=pc_o, trap_cause_o<=cause, trap_valid_o<=1, state<=HALT. pc_o is held and retired_o is not incremented.
  - ECALL (4): epc_o<=pc_o, cause<=4, trap_valid_o<=1, pc_o<=TRAP_VEC, retired_o+=1. State is unchanged (RUN stays RUN; STEP behaves as in the STEP rule).
  - EBREAK (5): epc_o<=pc_o, cause<=5, trap_valid_o<=1, state<=HALT, pc_o held, retired_o+=1.
- State transitions:
  - IDLE: run_i -> RUN; else step_i -> STEP; run_i takes priority if both are asserted. pc_o is held.
  - RUN: stays until a fatal event or EBREAK. run_i, step_i and resume_i are ignored.
  - STEP: lasts exactly one cycle. It processes one instruction per the action table, then goes to IDLE, or to HALT on fatal/EBREAK.
  - HALT: resume_i with trap_cause_o==5 sets pc_o<=epc_o+4 and state<=RUN. resume_i with a fatal cause is ignored; only reset exits. run_i and step_i are ignored.
- Arithmetic: retired_o wraps modulo 2^DATA_WIDTH. epc_o+4 wraps the same way.
- Latency: every transition and register update takes effect on the edge after sampling. All outputs are registered except halted_o, which is decoded from the state register.

Decomposition:
- Shared package hart_pkg holds:
  - the state enum (IDLE/RUN/STEP/HALT);
  - cause constants matching the core's interrupt bit indices (FetchError=0 … EBREAK=5) plus InstrMisaligned=6;
  - the helper is_fatal(cause).
  The core's interrupt index parameters are migrated to hart_pkg so both ends share one definition.
- One sub-module, trap_priority_encoder: combinational. Inputs interrupts_i and new_pc_i[1:0]; outputs event_valid and cause[2:0].

Test Plan:
- Reset, then run_i=1 for 1 cycle, with the core model returning new_pc=pc+4 and no events for 5 cycles -> pc_o = 0x0,0x4,…,0x14; retired_o=5; state_o=RUN.
- In RUN at pc=0x20, assert interrupts_i=6'b010000 (ECALL) -> next pc_o=0x100, epc_o=0x20, trap_cause_o=4, retired_o+1, state_o still RUN.
- At pc=0x40, assert interrupts_i=6'b100100 (MemAccess+EBREAK) -> cause=2 wins, state_o=HALT, pc_o held 0x40, retired_o unchanged; resume_i then has no effect.
- EBREAK alone at pc=0x80 -> HALT, cause=5; then resume_i -> pc_o=0x84, state_o=RUN one cycle later.
- From IDLE, pulse step_i with new_pc=0x8 -> pc_o=0x8, retired_o=1, state_o back to IDLE; a new_pc of 0x6 on the next step -> HALT, cause=6, epc_o=0x8.
- Deassert rst_ni asynchronously mid-RUN (between edges) -> all outputs return to reset values immediately, with pc_o=RESET_PC.
